glyph_pixel_reader: RTL and testbench

- Reads 8x16 glyph bitmaps out of the ASCII font pROM (4096x8, 16 bytes per glyph) and converts them into a row-major RGB565 pixel stream.
- Sits between the text/console controller (character requests) and the ST7735 SPI pixel writer (pixel stream).
- Owns the ROM read side: address generation, chip-enable, and alignment of the 1-cycle ROM read latency.

---
 rtl/glyph_pixel_reader_pkg.sv | 16 +
 rtl/glyph_pixel_reader_if.sv | 25 ++
 rtl/glyph_pixel_reader_row_shifter.sv | 51 +++++
 rtl/glyph_pixel_reader.sv | 116 +++++++++++
 tb/tb_glyph_pixel_reader.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/glyph_pixel_reader_pkg.sv
// Shared glyph geometry, the colour type, FSM state encoding and font ROM address packing.
package glyph_pixel_reader_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int ROM_AW  = 12;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, SHIFT} state_e;

    function automatic logic [ROM_AW-1:0] rom_addr(input logic [7:0] code, input logic [3:0] row);
        return {code, row};
    endfunction

endpackage

// File: rtl/glyph_pixel_reader_if.sv
// Character request handshake plus the outgoing pixel stream, as seen by the glyph reader.
interface glyph_pixel_reader_if;
    import glyph_pixel_reader_pkg::*;

    logic       char_valid;
    logic       char_ready;
    logic [7:0] char_code;
    rgb565_t    fg_color;
    rgb565_t    bg_color;
    logic       pix_valid;
    logic       pix_ready;
    rgb565_t    pix_data;
    logic       pix_eol;
    logic       pix_last;

    modport master (
        output char_valid, char_code, fg_color, bg_color, pix_ready,
        input  char_ready, pix_valid, pix_data, pix_eol, pix_last
    );

    modport slave (
        input  char_valid, char_code, fg_color, bg_color, pix_ready,
        output char_ready, pix_valid, pix_data, pix_eol, pix_last
    );
endinterface

// File: rtl/glyph_pixel_reader_row_shifter.sv
// One glyph row: loads a ROM byte (optionally bit-reversed so bit 7 is leftmost), shifts
// out one pixel per accepted beat and flags the last column.
module glyph_row_shifter
    import glyph_pixel_reader_pkg::*;
#(
    parameter int MSB_LEFT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] load_dat_i,
    input  logic       shift_i,
    output logic       msb_o,
    output logic       eol_o
);
    localparam int CW = $clog2(GLYPH_W);

    logic [7:0]    shreg_q, shreg_d;
    logic [CW-1:0] col_q, col_d;

    function automatic logic [7:0] bitrev(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    always_comb begin
        shreg_d = shreg_q;
        col_d   = col_q;
        if (load_i) begin
            shreg_d = (MSB_LEFT != 0) ? load_dat_i : bitrev(load_dat_i);
            col_d   = '0;
        end else if (shift_i) begin
            shreg_d = {shreg_q[6:0], 1'b0};
            col_d   = col_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            col_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            col_q   <= col_d;
        end
    end

    assign msb_o = shreg_q[7];
    assign eol_o = (col_q == CW'(GLYPH_W - 1));
endmodule

// File: rtl/glyph_pixel_reader.sv
// Fetches each glyph row from the font pROM and streams it out as RGB565 pixels, one row
// at a time; the FSM stalls in SHIFT while pix_ready is low.
module glyph_pixel_reader
    import glyph_pixel_reader_pkg::*;
#(
    parameter int GLYPH_ROWS = GLYPH_H,
    parameter int ROM_LAT    = 1,
    parameter int MSB_LEFT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    glyph_pixel_reader_if.slave bus_if,
    output logic [ROM_AW-1:0] rom_ad_o,
    output logic              rom_ce_o,
    output logic              rom_oce_o,
    input  logic [7:0]        rom_dout_i,
    output logic              busy_o
);
    localparam int         WCW      = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [3:0] ROW_LAST = 4'(GLYPH_ROWS - 1);

    state_e            state_q, state_d;
    logic [3:0]        row_q, row_d;
    logic [7:0]        code_q, code_d;
    rgb565_t           fg_q, fg_d, bg_q, bg_d;
    logic [ROM_AW-1:0] rom_ad_q, rom_ad_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic              load, shift, msb, eol;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        code_d   = code_q;
        fg_d     = fg_q;
        bg_d     = bg_q;
        rom_ad_d = rom_ad_q;
        wcnt_d   = wcnt_q;
        load     = 1'b0;
        shift    = 1'b0;
        case (state_q)
            IDLE: if (bus_if.char_valid) begin
                code_d   = bus_if.char_code;
                fg_d     = bus_if.fg_color;
                bg_d     = bus_if.bg_color;
                row_d    = 4'd0;
                rom_ad_d = rom_addr(bus_if.char_code, 4'd0);
                state_d  = FETCH;
            end
            FETCH: begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            // rom_dout is valid in the final WAIT cycle; capture it on that edge.
            WAIT: if (wcnt_q == WCW'(ROM_LAT - 1)) begin
                load    = 1'b1;
                state_d = SHIFT;
            end else begin
                wcnt_d = wcnt_q + WCW'(1);
            end
            SHIFT: if (bus_if.pix_ready) begin
                shift = 1'b1;
                if (eol) begin
                    if (row_q == ROW_LAST) begin
                        state_d = IDLE;
                    end else begin
                        row_d    = row_q + 4'd1;
                        rom_ad_d = rom_addr(code_q, row_q + 4'd1);
                        state_d  = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            code_q   <= '0;
            fg_q     <= '0;
            bg_q     <= '0;
            rom_ad_q <= '0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            code_q   <= code_d;
            fg_q     <= fg_d;
            bg_q     <= bg_d;
            rom_ad_q <= rom_ad_d;
            wcnt_q   <= wcnt_d;
        end
    end

    glyph_row_shifter #(.MSB_LEFT(MSB_LEFT)) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .load_dat_i (rom_dout_i),
        .shift_i    (shift),
        .msb_o      (msb),
        .eol_o      (eol)
    );

    assign rom_ad_o  = rom_ad_q;
    assign rom_ce_o  = (state_q == FETCH);
    assign rom_oce_o = 1'b1;
    assign busy_o    = (state_q != IDLE);

    assign bus_if.char_ready = (state_q == IDLE);
    assign bus_if.pix_valid  = (state_q == SHIFT);
    assign bus_if.pix_data   = (state_q == SHIFT) ? (msb ? fg_q : bg_q) : '0;
    assign bus_if.pix_eol    = (state_q == SHIFT) && eol;
    assign bus_if.pix_last   = (state_q == SHIFT) && eol && (row_q == ROW_LAST);
endmodule

// File: tb/tb_glyph_pixel_reader.sv
// Bench: two readers (MSB-left and LSB-left) against a glyph-level pixel/timing model.
module tb_glyph_pixel_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    glyph_pixel_reader_if if0();
    glyph_pixel_reader_if if1();

    logic [11:0] rom_ad0, rom_ad1;
    logic        rom_ce0, rom_ce1, oce0, oce1, busy0, busy1;
    logic [7:0]  rom_dout0 = 8'h00;
    logic [7:0]  rom_dout1 = 8'h00;

    glyph_pixel_reader #(.MSB_LEFT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus_if(if0),
        .rom_ad_o(rom_ad0), .rom_ce_o(rom_ce0), .rom_oce_o(oce0),
        .rom_dout_i(rom_dout0), .busy_o(busy0)
    );
    glyph_pixel_reader #(.MSB_LEFT(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus_if(if1),
        .rom_ad_o(rom_ad1), .rom_ce_o(rom_ce1), .rom_oce_o(oce1),
        .rom_dout_i(rom_dout1), .busy_o(busy1)
    );

    function automatic logic [7:0] rom_byte(input logic [11:0] a);
        logic [15:0] v;
        v = 16'(a[11:4]) * 16'd37 + 16'(a[3:0]) * 16'd11 + 16'd90;
        return v[7:0];
    endfunction

    always @(posedge clk) begin
        if (rom_ce0) rom_dout0 <= rom_byte(rom_ad0);
        if (rom_ce1) rom_dout1 <= rom_byte(rom_ad1);
    end

    logic        s_cr[2], s_pv[2], s_eol[2], s_last[2], s_ce[2], s_oce[2], s_busy[2], s_cv[2], s_prdy[2];
    logic [15:0] s_pd[2], s_fg[2], s_bg[2];
    logic [11:0] s_ad[2];
    logic [7:0]  s_code[2];
    always_comb begin
        s_cr[0] = if0.char_ready; s_pv[0] = if0.pix_valid; s_eol[0] = if0.pix_eol; s_last[0] = if0.pix_last;
        s_cr[1] = if1.char_ready; s_pv[1] = if1.pix_valid; s_eol[1] = if1.pix_eol; s_last[1] = if1.pix_last;
        s_pd[0] = if0.pix_data;   s_pd[1] = if1.pix_data;
        s_ce[0] = rom_ce0; s_ce[1] = rom_ce1; s_oce[0] = oce0; s_oce[1] = oce1;
        s_busy[0] = busy0; s_busy[1] = busy1; s_ad[0] = rom_ad0; s_ad[1] = rom_ad1;
        s_cv[0] = if0.char_valid; s_code[0] = if0.char_code; s_fg[0] = if0.fg_color; s_bg[0] = if0.bg_color;
        s_cv[1] = if1.char_valid; s_code[1] = if1.char_code; s_fg[1] = if1.fg_color; s_bg[1] = if1.bg_color;
        s_prdy[0] = if0.pix_ready; s_prdy[1] = if1.pix_ready;
    end

    typedef struct packed {
        logic [15:0] d;
        logic        eol;
        logic        last;
        logic [3:0]  row;
    } pix_t;

    pix_t        exp_p[2][128];
    int          rem[2], rd[2], gap[2], acc_cnt[2], acc_cyc[2], last_pop_cyc[2], first_v_cyc[2], obs_n[2];
    logic [7:0]  m_code[2];
    logic [15:0] obs_d[2][128];
    logic        obs_last[2][128], obs_eol[2][128];
    logic        prev_stall[2];
    logic [15:0] prev_pd[2];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  b_v;
    logic        bit_v, ev_v, rdy_v;

    task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] @cyc %0d: got 0x%0h, expected 0x%0h", nm, k, cyc, act, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; rd[k] = 0; gap[k] = 0; acc_cnt[k] = 0; acc_cyc[k] = 0;
            last_pop_cyc[k] = 0; first_v_cyc[k] = -1; obs_n[k] = 0; prev_stall[k] = 1'b0; prev_pd[k] = '0;
        end
    end

    // Model: a glyph is 128 pixels from rom_byte(); each row is preceded by a 2-cycle
    // gap (ROM fetch + wait) during which the only expected activity is rom_ce.
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                chk(k, "rst_char_ready", 32'(s_cr[k]), 32'd1);
                chk(k, "rst_rom_ce", 32'(s_ce[k]), 32'd0);
                chk(k, "rst_rom_ad", 32'(s_ad[k]), 32'd0);
                chk(k, "rst_pix_valid", 32'(s_pv[k]), 32'd0);
                chk(k, "rst_pix_data", 32'(s_pd[k]), 32'd0);
                chk(k, "rst_eol_last", 32'({s_eol[k], s_last[k]}), 32'd0);
                chk(k, "rst_busy", 32'(s_busy[k]), 32'd0);
                rem[k] = 0; gap[k] = 0; prev_stall[k] = 1'b0;
            end else begin
                rdy_v = (rem[k] == 0);
                ev_v  = (rem[k] > 0) && (gap[k] == 0);
                chk(k, "char_ready", 32'(s_cr[k]), 32'(rdy_v));
                chk(k, "busy", 32'(s_busy[k]), 32'(!rdy_v));
                chk(k, "rom_oce", 32'(s_oce[k]), 32'd1);
                chk(k, "rom_ce", 32'(s_ce[k]), 32'((rem[k] > 0) && (gap[k] == 2)));
                if (s_ce[k] && rem[k] > 0)
                    chk(k, "rom_ad", 32'(s_ad[k]), 32'({m_code[k], exp_p[k][rd[k]].row}));
                chk(k, "pix_valid", 32'(s_pv[k]), 32'(ev_v));
                if (ev_v && s_pv[k]) begin
                    chk(k, "pix_data", 32'(s_pd[k]), 32'(exp_p[k][rd[k]].d));
                    chk(k, "pix_eol_last", 32'({s_eol[k], s_last[k]}),
                        32'({exp_p[k][rd[k]].eol, exp_p[k][rd[k]].last}));
                end
                if (prev_stall[k]) chk(k, "stall_stable", 32'(s_pd[k]), 32'(prev_pd[k]));
                if (s_pv[k] && first_v_cyc[k] < 0) first_v_cyc[k] = cyc;
                if (s_pv[k] && s_prdy[k] && obs_n[k] < 128) begin
                    obs_d[k][obs_n[k]] = s_pd[k];
                    obs_eol[k][obs_n[k]] = s_eol[k];
                    obs_last[k][obs_n[k]] = s_last[k];
                    obs_n[k]++;
                end
                prev_stall[k] = s_pv[k] && !s_prdy[k];
                prev_pd[k] = s_pd[k];
                if (gap[k] > 0) begin
                    gap[k]--;
                end else if (ev_v && s_prdy[k]) begin
                    if (exp_p[k][rd[k]].last) last_pop_cyc[k] = cyc;
                    else if (exp_p[k][rd[k]].eol) gap[k] = 2;
                    rd[k]++;
                    rem[k]--;
                end
                if (rdy_v && s_cv[k]) begin
                    for (int r = 0; r < 16; r++) begin
                        b_v = rom_byte({s_code[k], 4'(r)});
                        for (int c = 0; c < 8; c++) begin
                            bit_v = (k == 0) ? b_v[7-c] : b_v[c];
                            exp_p[k][r*8+c] = '{d: bit_v ? s_fg[k] : s_bg[k], eol: (c == 7),
                                               last: (r == 15 && c == 7), row: 4'(r)};
                        end
                    end
                    m_code[k] = s_code[k];
                    rem[k] = 128; rd[k] = 0; gap[k] = 2;
                    acc_cyc[k] = cyc; first_v_cyc[k] = -1; obs_n[k] = 0;
                    acc_cnt[k]++;
                end
            end
        end
    end

    task automatic set_in(input int k, input logic v, input logic [7:0] code,
                          input logic [15:0] fg, input logic [15:0] bg);
        if (k == 0) begin
            if0.char_valid = v; if0.char_code = code; if0.fg_color = fg; if0.bg_color = bg;
        end else begin
            if1.char_valid = v; if1.char_code = code; if1.fg_color = fg; if1.bg_color = bg;
        end
    endtask

    task automatic set_rdy(input int k, input logic r);
        if (k == 0) if0.pix_ready = r;
        else        if1.pix_ready = r;
    endtask

    task automatic request(input int k, input logic [7:0] code, input logic [15:0] fg,
                           input logic [15:0] bg, input bit keep);
        int n0, t;
        n0 = acc_cnt[k];
        t  = 0;
        set_in(k, 1'b1, code, fg, bg);
        while (acc_cnt[k] == n0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk(k, "accept_timeout", 32'(t < 500), 32'd1);
        #1;
        if (!keep) set_in(k, 1'b0, code, fg, bg);
    endtask

    task automatic wait_done(input int k, input bit rnd);
        int t;
        t = 0;
        while (rem[k] > 0 && t < 3000) begin
            @(posedge clk);
            #1;
            if (rnd) set_rdy(k, 1'($urandom_range(0, 1)));
            t++;
        end
        set_rdy(k, 1'b1);
        chk(k, "glyph_timeout", 32'(t < 3000), 32'd1);
    endtask

    logic [15:0] ref_d[128];
    int          nmis, nbg, nlast, neol, t;

    initial begin
        set_in(0, 1'b0, 8'h00, 16'h0000, 16'h0000);
        set_in(1, 1'b0, 8'h00, 16'h0000, 16'h0000);
        set_rdy(0, 1'b1);
        set_rdy(1, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 0x41 white-on-black; inputs scrambled right after accept must not matter
        request(0, 8'h41, 16'hFFFF, 16'h0000, 1'b0);
        set_in(0, 1'b0, 8'h99, 16'h1234, 16'h5678);
        wait_done(0, 1'b0);
        chk(0, "n_pixels", 32'(obs_n[0]), 32'd128);
        chk(0, "first_pix_latency", 32'(first_v_cyc[0] - acc_cyc[0]), 32'd3);
        chk(0, "glyph_cycles", 32'(last_pop_cyc[0] - acc_cyc[0]), 32'd160);
        chk(0, "px0_rom_BF", 32'(obs_d[0][0]), 32'hFFFF);
        chk(0, "px1_rom_BF", 32'(obs_d[0][1]), 32'h0000);
        chk(0, "px2_rom_BF", 32'(obs_d[0][2]), 32'hFFFF);
        chk(0, "px125_rom_64", 32'(obs_d[0][125]), 32'hFFFF);
        chk(0, "px127_rom_64", 32'(obs_d[0][127]), 32'h0000);
        nlast = 0; neol = 0;
        for (int i = 0; i < 128; i++) begin
            if (obs_last[0][i]) nlast++;
            if (obs_eol[0][i] && (i % 8 == 7)) neol++;
        end
        chk(0, "eol_every_8th", 32'(neol), 32'd16);
        chk(0, "last_once", 32'(nlast), 32'd1);
        chk(0, "last_on_px128", 32'(obs_last[0][127]), 32'd1);
        @(negedge clk);
        chk(0, "ready_after_last", 32'(if0.char_ready), 32'd1);
        @(posedge clk); #1;

        // 0x7E at full rate, then with random backpressure
        request(0, 8'h7E, 16'hF800, 16'h001F, 1'b0);
        wait_done(0, 1'b0);
        for (int i = 0; i < 128; i++) ref_d[i] = obs_d[0][i];
        request(0, 8'h7E, 16'hF800, 16'h001F, 1'b0);
        wait_done(0, 1'b1);
        nmis = 0;
        for (int i = 0; i < 128; i++) if (obs_d[0][i] !== ref_d[i]) nmis++;
        chk(0, "stall_seq_match", 32'(nmis), 32'd0);
        chk(0, "stall_n_pixels", 32'(obs_n[0]), 32'd128);

        // back-to-back with char_valid held high
        request(0, 8'h20, 16'h07E0, 16'h0000, 1'b1);
        set_in(0, 1'b1, 8'hFF, 16'hFFE0, 16'h0010);
        request(0, 8'hFF, 16'hFFE0, 16'h0010, 1'b0);
        chk(0, "b2b_gap", 32'(acc_cyc[0] - last_pop_cyc[0]), 32'd1);
        wait_done(0, 1'b0);
        chk(0, "b2b_second_n", 32'(obs_n[0]), 32'd128);

        // LSB-left build: 0xDB row 0 reads 0x01
        chk(1, "rom_model_DB0", 32'(rom_byte(12'hDB0)), 32'h01);
        request(1, 8'hDB, 16'hAAAA, 16'h5555, 1'b0);
        wait_done(1, 1'b0);
        chk(1, "lsb_px0_fg", 32'(obs_d[1][0]), 32'hAAAA);
        nbg = 0;
        for (int i = 1; i < 8; i++) if (obs_d[1][i] === 16'h5555) nbg++;
        chk(1, "lsb_px1_7_bg", 32'(nbg), 32'd7);

        // reset after pixel 50 of 0x33, then a full redo
        request(0, 8'h33, 16'hC618, 16'h2104, 1'b0);
        t = 0;
        while (obs_n[0] < 50 && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk(0, "reach_px50", 32'(t < 500), 32'd1);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk(0, "partial_n", 32'(obs_n[0]), 32'd50);
        nlast = 0;
        for (int i = 0; i < 50; i++) if (obs_last[0][i]) nlast++;
        chk(0, "partial_no_last", 32'(nlast), 32'd0);
        @(posedge clk); #1;
        request(0, 8'h33, 16'hC618, 16'h2104, 1'b0);
        wait_done(0, 1'b0);
        chk(0, "redo_n", 32'(obs_n[0]), 32'd128);
        chk(0, "redo_last", 32'(obs_last[0][127]), 32'd1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
